// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_if
// Description : Byte-stream input and instruction-store write port of the
//               instruction-memory loader, plus its status signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if #(
    parameter int ADDR_W = 8
) ();
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata,
        input  cpu_hold, done, error, words_loaded
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata,
        output cpu_hold, done, error, words_loaded
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Packs a framed byte stream (16-bit word count, MSB-first data
//               words, XOR checksum) into 32-bit instruction-store writes.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    imem_loader_if.slave    bus
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_hdr_hi = 3'd1;
    localparam logic [2:0] c_st_hdr_lo = 3'd2;
    localparam logic [2:0] c_st_data   = 3'd3;
    localparam logic [2:0] c_st_write  = 3'd4;
    localparam logic [2:0] c_st_check  = 3'd5;
    localparam logic [2:0] c_st_done   = 3'd6;
    localparam logic [2:0] c_st_err    = 3'd7;

    localparam logic [16:0] c_depth = 17'(DEPTH);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [15:0]       r_count;
    logic [23:0]       r_shift;
    logic [1:0]        r_byte_idx;
    logic [7:0]        r_xor;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_words;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;

    logic              w_in_ready;
    logic              w_mem_we;
    logic              w_cpu_hold;
    logic              w_done;
    logic              w_error;
    logic              w_xfer;
    logic              w_start_ok;
    logic [15:0]       w_count_full;
    logic [ADDR_W:0]   w_words_inc;
    logic              w_last_word;

    assign w_xfer       = bus.in_valid && w_in_ready;
    assign w_start_ok   = bus.start && ((r_state == c_st_idle) ||
                                        (r_state == c_st_done) ||
                                        (r_state == c_st_err));
    assign w_count_full = {r_count[15:8], bus.in_data};
    assign w_words_inc  = r_words + 1'b1;
    assign w_last_word  = (16'(w_words_inc) == r_count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_mem_we    = 1'b0;
        w_cpu_hold  = 1'b0;
        w_done      = 1'b0;
        w_error     = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (bus.start) w_state_nxt = c_st_hdr_hi;
            end
            c_st_hdr_hi: begin
                w_in_ready = 1'b1;
                w_cpu_hold = 1'b1;
                if (w_xfer) w_state_nxt = c_st_hdr_lo;
            end
            c_st_hdr_lo: begin
                w_in_ready = 1'b1;
                w_cpu_hold = 1'b1;
                if (w_xfer) begin
                    if ({1'b0, w_count_full} > c_depth) w_state_nxt = c_st_err;
                    else if (w_count_full == 16'd0)     w_state_nxt = c_st_check;
                    else                                w_state_nxt = c_st_data;
                end
            end
            c_st_data: begin
                w_in_ready = 1'b1;
                w_cpu_hold = 1'b1;
                if (w_xfer && (r_byte_idx == 2'd3)) w_state_nxt = c_st_write;
            end
            c_st_write: begin
                w_mem_we    = 1'b1;
                w_cpu_hold  = 1'b1;
                w_state_nxt = w_last_word ? c_st_check : c_st_data;
            end
            c_st_check: begin
                w_in_ready = 1'b1;
                w_cpu_hold = 1'b1;
                if (w_xfer) w_state_nxt = (bus.in_data == r_xor) ? c_st_done : c_st_err;
            end
            c_st_done: begin
                w_done = 1'b1;
                if (bus.start) w_state_nxt = c_st_hdr_hi;
            end
            c_st_err: begin
                w_error = 1'b1;
                if (bus.start) w_state_nxt = c_st_hdr_hi;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // Write port registers are loaded on the 4th data byte so they are valid
    // during WRITE and then hold until the next word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_shift     <= '0;
            r_byte_idx  <= '0;
            r_xor       <= '0;
            r_addr      <= '0;
            r_words     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_start_ok) begin
            r_byte_idx <= '0;
            r_xor      <= '0;
            r_addr     <= '0;
            r_words    <= '0;
        end else begin
            if (w_xfer && (r_state != c_st_check)) begin
                r_xor <= r_xor ^ bus.in_data;
            end
            if (w_xfer && (r_state == c_st_hdr_hi)) r_count[15:8] <= bus.in_data;
            if (w_xfer && (r_state == c_st_hdr_lo)) r_count[7:0]  <= bus.in_data;
            if (w_xfer && (r_state == c_st_data)) begin
                r_shift    <= {r_shift[15:0], bus.in_data};
                r_byte_idx <= r_byte_idx + 2'd1;
                if (r_byte_idx == 2'd3) begin
                    r_mem_wdata <= {r_shift, bus.in_data};
                    r_mem_addr  <= r_addr;
                end
            end
            if (r_state == c_st_write) begin
                r_addr  <= r_addr + 1'b1;
                r_words <= w_words_inc;
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.mem_we       = w_mem_we;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_wdata    = r_mem_wdata;
    assign bus.cpu_hold     = w_cpu_hold;
    assign bus.done         = w_done;
    assign bus.error        = w_error;
    assign bus.words_loaded = r_words;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed + randomized frames for imem_loader, compared against
//               a frame-level reference model (expected writes and status).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [ADDR_W+31:0] wr_log[$];
    logic [31:0]        exp_words[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every write strobe is logged; a byte must never be accepted alongside it.
    always @(negedge clk) begin
        if (rst_n && bus.mem_we) begin
            wr_log.push_back({bus.mem_addr, bus.mem_wdata});
            check("ready_during_write", 64'(bus.in_ready), 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max, output bit ok);
        int g;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        if (g > 0) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            repeat (g) tick();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            ok = bus.in_ready;
            tick();
        end
        if (!ok) check("byte_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_in_ready"},     64'(bus.in_ready),     64'd0);
        check({tag, "_mem_we"},       64'(bus.mem_we),       64'd0);
        check({tag, "_mem_addr"},     64'(bus.mem_addr),     64'd0);
        check({tag, "_mem_wdata"},    64'(bus.mem_wdata),    64'd0);
        check({tag, "_cpu_hold"},     64'(bus.cpu_hold),     64'd0);
        check({tag, "_done"},         64'(bus.done),         64'd0);
        check({tag, "_error"},        64'(bus.error),        64'd0);
        check({tag, "_words_loaded"}, 64'(bus.words_loaded), 64'd0);
    endtask

    // Reference model: the frame is built from exp_words, the checksum is the
    // XOR of every header/data byte, and the outcome follows from N and ck.
    task automatic run_frame(input logic [15:0] n, input bit bad_ck,
                             input int gap_max, input bit mid_start);
        logic [7:0] bytes[$];
        logic [7:0] x;
        bit         ok;
        bit         oversize;
        int         waited;
        int         n_exp;

        oversize = (int'(n) > DEPTH);
        n_exp    = oversize ? 0 : int'(n);
        bytes.push_back(n[15:8]);
        bytes.push_back(n[7:0]);
        if (!oversize) begin
            for (int i = 0; i < n_exp; i++) begin
                bytes.push_back(exp_words[i][31:24]);
                bytes.push_back(exp_words[i][23:16]);
                bytes.push_back(exp_words[i][15:8]);
                bytes.push_back(exp_words[i][7:0]);
            end
            x = 8'h00;
            foreach (bytes[i]) x = x ^ bytes[i];
            bytes.push_back(bad_ck ? (x ^ 8'(1 + $urandom_range(254, 0))) : x);
        end

        wr_log.delete();
        pulse_start();
        check("hold_after_start", 64'(bus.cpu_hold), 64'd1);
        check("done_cleared",     64'(bus.done | bus.error), 64'd0);

        ok = 1'b1;
        foreach (bytes[i]) begin
            if (ok) begin
                if (mid_start && i == 3) begin
                    bus.in_valid = 1'b0;
                    pulse_start();
                end
                send_byte(bytes[i], gap_max, ok);
            end
        end
        bus.in_valid = 1'b0;

        waited = 0;
        while (!(bus.done || bus.error) && waited < 10) begin
            tick();
            waited++;
        end
        check("settle_cycles", 64'(waited), 64'd0);

        check("n_writes", 64'(wr_log.size()), 64'(n_exp));
        for (int i = 0; i < n_exp && i < wr_log.size(); i++) begin
            check("wr_addr", 64'(wr_log[i][ADDR_W+31:32]), 64'(i));
            check("wr_data", 64'(wr_log[i][31:0]),         64'(exp_words[i]));
        end
        check("done",         64'(bus.done),         64'(!oversize && !bad_ck));
        check("error",        64'(bus.error),        64'(oversize || bad_ck));
        check("words_loaded", 64'(bus.words_loaded), 64'(n_exp));
        check("hold_released",64'(bus.cpu_hold),     64'd0);
        check("ready_idle",   64'(bus.in_ready),     64'd0);
    endtask

    task automatic rand_words(input int n);
        exp_words.delete();
        for (int i = 0; i < n; i++) exp_words.push_back($urandom);
    endtask

    initial begin
        bit ok;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_idle_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single word: 00 01 8C 02 00 00 8F
        exp_words = '{32'h8C020000};
        run_frame(16'd1, 1'b0, 0, 1'b0);

        exp_words = '{32'h00001820, 32'h00012020, 32'h00003020};
        run_frame(16'd3, 1'b0, 0, 1'b0);

        rand_words(2);
        run_frame(16'd2, 1'b1, 0, 1'b0);

        // Oversize header: later bytes must be refused.
        run_frame(16'd257, 1'b0, 0, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("oversize_refuse", 64'(bus.in_ready), 64'd0);
            tick();
        end
        bus.in_valid = 1'b0;
        check("oversize_no_write", 64'(wr_log.size()), 64'd0);
        check("oversize_error_persist", 64'(bus.error), 64'd1);

        exp_words.delete();
        run_frame(16'd0, 1'b0, 0, 1'b0);

        rand_words(2);
        run_frame(16'd2, 1'b0, 1, 1'b1);

        // Reset after two data bytes abandons the frame immediately.
        wr_log.delete();
        pulse_start();
        send_byte(8'h00, 0, ok);
        send_byte(8'h02, 0, ok);
        send_byte(8'h12, 0, ok);
        send_byte(8'h34, 0, ok);
        rst_n = 1'b0;
        #1;
        check_idle_reset("async_reset");
        check("reset_no_write", 64'(wr_log.size()), 64'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        rand_words(1);
        run_frame(16'd1, 1'b0, 0, 1'b0);

        rand_words(4);
        run_frame(16'd4, 1'b0, 3, 1'b0);

        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(6, 1));
            rand_words(n);
            run_frame(16'(n), 1'($urandom_range(1, 0)), int'($urandom_range(3, 0)), 1'b0);
        end

        // Full store: last write lands on DEPTH-1.
        rand_words(DEPTH);
        run_frame(16'(DEPTH), 1'b0, 0, 1'b0);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
